// File: rtl/log2_iter.sv
// Iterative fixed-point log2: leading-one normalise, then one fraction bit per
// cycle by repeated squaring of the Q1.FRAC mantissa. One operation in flight.
module log2_iter #(
  parameter int D_W = 16
) (
  input  logic           I_CLK,
  input  logic           I_RST,
  input  logic           I_VALID,
  output logic           O_READY,
  input  logic [D_W-1:0] I_DATA,
  output logic           O_VALID,
  input  logic           I_READY,
  output logic [D_W-1:0] O_DATA,
  output logic           O_ERR
);

  localparam int FRAC  = D_W - 3;
  localparam int M_W   = FRAC + 1;
  localparam int CNT_W = $clog2(FRAC);
  localparam logic [D_W-1:0] SAT_WORD = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [D_W-1:0]      r_x;
  logic [M_W-1:0]      r_m;
  logic [FRAC-2:0]     r_frac;
  logic signed [2:0]   r_e;
  logic [CNT_W-1:0]    r_cnt;
  logic [D_W-1:0]      r_data;
  logic                r_err;

  logic [4:0]          w_p;
  logic                w_err_in;
  logic                w_sat;
  logic [M_W-1:0]      w_m_norm;
  logic [2*FRAC+1:0]   w_q;
  logic                w_bit;
  logic [M_W-1:0]      w_m_sq;
  logic [FRAC-1:0]     w_unused_q;
  logic                w_last;

  function automatic logic [4:0] f_lead_one(input logic [D_W-2:0] v);
    logic [4:0] p;
    p = '0;
    for (int i = 0; i < D_W-1; i++)
      if (v[i]) p = 5'(i);
    return p;
  endfunction

  // Truncating square step: keep the top M_W bits, leading one back at bit FRAC.
  function automatic logic [M_W:0] f_sq_trunc(input logic [2*FRAC+1:0] q);
    if (q[2*FRAC+1]) return {1'b1, q[2*FRAC+1:FRAC+1]};
    else             return {1'b0, q[2*FRAC:FRAC]};
  endfunction

  // Integer part e in [-4,1] fits the 3 bits above the fraction exactly.
  function automatic logic [D_W-1:0] f_pack(input logic signed [2:0] e,
                                            input logic [FRAC-1:0] frac);
    return {e, frac};
  endfunction

  // Normalise stage
  always_comb begin
    w_p      = f_lead_one(r_x[D_W-2:0]);
    w_err_in = r_x[D_W-1] | (r_x == '0);
    w_sat    = (w_p < 5'(FRAC-4));
    if (w_p == 5'(FRAC+1)) w_m_norm = r_x[FRAC+1:1];
    else                   w_m_norm = M_W'(r_x[D_W-2:0] << (5'(FRAC) - w_p));
  end

  // Iteration stage
  always_comb begin
    w_q          = {{M_W{1'b0}}, r_m} * {{M_W{1'b0}}, r_m};
    {w_bit, w_m_sq} = f_sq_trunc(w_q);
    w_unused_q   = w_q[FRAC-1:0];
    w_last       = (r_cnt == CNT_W'(FRAC-1));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (I_VALID) w_state_nxt = S_NORM;
      S_NORM:  w_state_nxt = (w_err_in || w_sat) ? S_DONE : S_ITER;
      S_ITER:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (I_READY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_NORM: begin
          r_cnt <= '0;
          if (w_err_in) begin
            r_data <= SAT_WORD;
            r_err  <= 1'b1;
          end else if (w_sat) begin
            r_data <= SAT_WORD;
            r_err  <= 1'b0;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_data <= f_pack(r_e, {r_frac, w_bit});
            r_err  <= 1'b0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    case (r_state)
      S_IDLE: if (I_VALID) r_x <= I_DATA;
      S_NORM: begin
        r_m    <= w_m_norm;
        r_e    <= 3'(w_p - 5'(FRAC));
        r_frac <= '0;
      end
      S_ITER: begin
        r_m    <= w_m_sq;
        r_frac <= {r_frac[FRAC-3:0], w_bit};
      end
      default: ;
    endcase
  end

  assign O_READY = (r_state == S_IDLE);
  assign O_VALID = (r_state == S_DONE);
  assign O_DATA  = r_data;
  assign O_ERR   = r_err;

endmodule

// File: tb/tb_log2_iter.sv
// Directed and randomized checks of log2_iter at D_W=16 and D_W=8 against an
// integer model of the normalise/square-and-truncate algorithm.
module tb_log2_iter;

  logic        clk;
  logic        rst;
  logic        i16_valid, i16_ready, o16_ready, o16_valid, o16_err;
  logic [15:0] i16_data, o16_data;
  logic        i8_valid, i8_ready, o8_ready, o8_valid, o8_err;
  logic [7:0]  i8_data, o8_data;

  int n_cmp = 0;
  int n_bad = 0;

  log2_iter #(.D_W(16)) u_dut16 (
    .I_CLK(clk), .I_RST(rst), .I_VALID(i16_valid), .O_READY(o16_ready),
    .I_DATA(i16_data), .O_VALID(o16_valid), .I_READY(i16_ready),
    .O_DATA(o16_data), .O_ERR(o16_err)
  );

  log2_iter #(.D_W(8)) u_dut8 (
    .I_CLK(clk), .I_RST(rst), .I_VALID(i8_valid), .O_READY(o8_ready),
    .I_DATA(i8_data), .O_VALID(o8_valid), .I_READY(i8_ready),
    .O_DATA(o8_data), .O_ERR(o8_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {err, data}: log2 of x in s.ii.f with FRAC=dw-3, truncated.
  function automatic logic [16:0] ref_log2(input int dw, input longint x);
    int     frac;
    int     p;
    int     e;
    longint m, q, r, mask;
    frac = dw - 3;
    mask = (longint'(1) << dw) - 1;
    if (x >= (longint'(1) << (dw-1)) || x == 0)
      return {1'b1, 16'(longint'(1) << (dw-1))};
    p = 0;
    while ((longint'(1) << (p+1)) <= x) p++;
    e = p - frac;
    if (e < -4) return {1'b0, 16'(longint'(1) << (dw-1))};
    m = (p > frac) ? (x >> (p-frac)) : (x << (frac-p));
    r = 0;
    for (int k = 0; k < frac; k++) begin
      q = m * m;
      if (q >= (longint'(1) << (2*frac+1))) begin
        r = r*2 + 1;
        m = q >> (frac+1);
      end else begin
        r = r*2;
        m = q >> frac;
      end
    end
    return {1'b0, 16'((longint'(e) * (longint'(1) << frac) + r) & mask)};
  endfunction

  task automatic send(input bit w8, input logic [15:0] d, output int lat);
    int guard;
    guard = 0;
    if (w8) begin i8_data = d[7:0]; i8_valid = 1'b1; end
    else    begin i16_data = d;     i16_valid = 1'b1; end
    while (!(w8 ? o8_ready : o16_ready) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    i8_valid  = 1'b0;
    i16_valid = 1'b0;
    lat = 1;
    while (!(w8 ? o8_valid : o16_valid) && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_xfer();
    i8_ready  = 1'b1;
    i16_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input bit w8, input logic [15:0] d,
                       output logic [15:0] od, output logic oe, output int lat);
    send(w8, d, lat);
    check(w8 ? "valid8" : "valid16", {31'd0, w8 ? o8_valid : o16_valid}, 32'd1);
    od = w8 ? {8'h00, o8_data} : o16_data;
    oe = w8 ? o8_err : o16_err;
    finish_xfer();
  endtask

  initial begin
    logic [15:0] od;
    logic        oe;
    int          lat;
    logic [16:0] exp;
    logic [15:0] x;

    rst = 1'b1;
    i16_valid = 1'b0; i16_ready = 1'b1; i16_data = '0;
    i8_valid  = 1'b0; i8_ready  = 1'b1; i8_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  {31'd0, o16_ready}, 32'd1);
    check("rst_valid",  {31'd0, o16_valid}, 32'd0);
    check("rst_data",   {16'd0, o16_data},  32'd0);
    check("rst_err",    {31'd0, o16_err},   32'd0);
    check("rst_valid8", {31'd0, o8_valid},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1
    do_op(1'b0, 16'h2000, od, oe, lat);
    check("t1_data", {16'd0, od}, 32'h0000);
    check("t1_err",  {31'd0, oe}, 32'd0);
    check("t1_lat",  lat, 15);
    check("t1_ready_after", {31'd0, o16_ready}, 32'd1);

    // T2
    do_op(1'b0, 16'h4000, od, oe, lat);
    check("t2_2p0", {16'd0, od}, 32'h2000);
    do_op(1'b0, 16'h1000, od, oe, lat);
    check("t2_0p5", {16'd0, od}, 32'hE000);
    do_op(1'b0, 16'h6000, od, oe, lat);
    check("t2_3p0", {16'd0, (od == 16'h32B7) ? 16'h32B8 : od}, 32'h32B8);
    check("t2_3p0_model", {16'd0, od}, {16'd0, ref_log2(16, 64'h6000)});

    // T3
    do_op(1'b0, 16'h0000, od, oe, lat);
    check("t3_zero_data", {16'd0, od}, 32'h8000);
    check("t3_zero_err",  {31'd0, oe}, 32'd1);
    check("t3_zero_lat",  lat, 2);
    do_op(1'b0, 16'hC000, od, oe, lat);
    check("t3_neg_data", {16'd0, od}, 32'h8000);
    check("t3_neg_err",  {31'd0, oe}, 32'd1);
    do_op(1'b0, 16'h0001, od, oe, lat);
    check("t3_sat_data", {16'd0, od}, 32'h8000);
    check("t3_sat_err",  {31'd0, oe}, 32'd0);
    check("t3_sat_lat",  lat, 2);

    // T4: downstream stall
    i16_ready = 1'b0;
    send(1'b0, 16'h4000, lat);
    for (int c = 0; c < 10; c++) begin
      check("t4_hold_valid", {31'd0, o16_valid}, 32'd1);
      check("t4_hold_data",  {16'd0, o16_data},  32'h2000);
      check("t4_hold_ready", {31'd0, o16_ready}, 32'd0);
      @(posedge clk); #1;
    end
    i16_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_after_valid", {31'd0, o16_valid}, 32'd0);
    check("t4_after_ready", {31'd0, o16_ready}, 32'd1);

    // T5: reset during iteration 5
    i16_data = 16'h2000; i16_valid = 1'b1;
    @(posedge clk); #1;
    i16_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_busy_ready", {31'd0, o16_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_rst_valid", {31'd0, o16_valid}, 32'd0);
    check("t5_rst_ready", {31'd0, o16_ready}, 32'd1);
    do_op(1'b0, 16'h4000, od, oe, lat);
    check("t5_fresh_data", {16'd0, od}, 32'h2000);
    check("t5_fresh_lat",  lat, 15);

    // T6: D_W = 8
    do_op(1'b1, 16'h0020, od, oe, lat);
    check("t6_1p0", {16'd0, od}, 32'h00);
    check("t6_lat", lat, 7);
    do_op(1'b1, 16'h0040, od, oe, lat);
    check("t6_2p0", {16'd0, od}, 32'h20);
    do_op(1'b1, 16'h0010, od, oe, lat);
    check("t6_0p5", {16'd0, od}, 32'hE0);

    for (int n = 0; n < 40; n++) begin
      x = 16'($urandom_range(0, 255));
      exp = ref_log2(8, longint'(x));
      do_op(1'b1, x, od, oe, lat);
      check("rnd8_data", {16'd0, od}, {16'd0, 8'h00, exp[7:0]});
      check("rnd8_err",  {31'd0, oe}, {31'd0, exp[16]});
    end

    for (int n = 0; n < 30; n++) begin
      x = 16'($urandom_range(0, 65535));
      if (n % 4 != 0) x[15] = 1'b0;
      exp = ref_log2(16, longint'(x));
      do_op(1'b0, x, od, oe, lat);
      check("rnd16_data", {16'd0, od}, {16'd0, exp[15:0]});
      check("rnd16_err",  {31'd0, oe}, {31'd0, exp[16]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
